// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the EX-stage forwarding scoreboard.
// One entry per post-EX stage; the fwd_sel encoding is defined here so the datapath mux decode uses the same values.
package fwd_scoreboard_pkg;

  // Sized to hold an entry index for any DEPTH up to 16.
  localparam int STAGE_W        = 4;
  localparam int FWD_NONE       = 0;
  localparam int FWD_ENTRY_BASE = 1;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rd;
    logic               load_reg;
    logic [STAGE_W-1:0] ready_stage;
  } entry_t;

  function automatic logic entry_matches(input entry_t e, input logic [4:0] rs);
    return e.valid && e.load_reg && (e.rd != 5'd0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the EX stage control (master) and the forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
);
  localparam int RS_W = $clog2(DEPTH);

  // There is no valid/ready handshake here: advance is a global enable. While
  // advance=0 the scoreboard holds, and fwd_sel/stall keep reflecting held state.
  logic                            advance;
  logic                            flush;
  logic                            ex_valid;
  logic [4:0]                      ex_rd;
  logic                            ex_load_reg;
  logic [RS_W-1:0]                 ex_ready_stage;
  logic [NUM_SRC-1:0][4:0]         ex_rs;
  logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel;
  logic                            stall;
  logic [31:0]                     stall_count;

  modport master (
    output advance, flush, ex_valid, ex_rd, ex_load_reg, ex_ready_stage, ex_rs,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  advance, flush, ex_valid, ex_rd, ex_load_reg, ex_ready_stage, ex_rs,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard_operand.sv
// Per-source-operand priority match and readiness check.
// The youngest (lowest-index) matching entry wins; older matches are shadowed.
module fwd_operand_select
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic [4:0]         rs,
  input  logic               ex_valid,
  output logic [SEL_W-1:0]   sel,
  output logic               not_ready
);

  logic               hit;
  logic [STAGE_W-1:0] hit_idx;
  logic [STAGE_W-1:0] hit_rdy;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_rdy = '0;
    // Scan oldest to youngest so the youngest match is the last one written.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entry_matches(entries[k], rs)) begin
        hit     = 1'b1;
        hit_idx = STAGE_W'(k);
        hit_rdy = entries[k].ready_stage;
      end
    end

    sel       = SEL_W'(FWD_NONE);
    not_ready = 1'b0;
    if (hit) begin
      if (hit_idx >= hit_rdy) sel = SEL_W'(hit_idx) + SEL_W'(FWD_ENTRY_BASE);
      else                    not_ready = ex_valid;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shift register of post-EX entries plus per-operand
// forward-select / load-use stall resolution and a saturating stall counter.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);

  entry_t [DEPTH-1:0]            entries;
  entry_t                        ex_entry;
  logic [NUM_SRC-1:0]            src_not_ready;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_vec;
  logic                          stall_int;
  logic                          load_en;
  logic [31:0]                   stall_count_q;

  always_comb begin
    ex_entry             = '0;
    ex_entry.valid       = 1'b1;
    ex_entry.rd          = bus.ex_rd;
    ex_entry.load_reg    = bus.ex_load_reg;
    ex_entry.ready_stage = STAGE_W'(bus.ex_ready_stage);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_select #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_sel (
      .entries   (entries),
      .rs        (bus.ex_rs[i]),
      .ex_valid  (bus.ex_valid),
      .sel       (sel_vec[i]),
      .not_ready (src_not_ready[i])
    );
  end

  assign stall_int       = |src_not_ready;
  // A stalled or flushed EX instruction leaves a single bubble behind it.
  assign load_en         = bus.ex_valid && !stall_int && !bus.flush;
  assign bus.fwd_sel     = sel_vec;
  assign bus.stall       = stall_int;
  assign bus.stall_count = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      entries       <= '0;
      stall_count_q <= '0;
    end else if (bus.advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) entries[k] <= entries[k-1];
      entries[0] <= load_en ? ex_entry : '0;
      if (stall_int && (stall_count_q != 32'hFFFF_FFFF))
        stall_count_q <= stall_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios plus randomized traffic,
// all checked against a queue-based model of the in-flight instruction history.
module tb_fwd_scoreboard;
  localparam int DEPTH   = 3;
  localparam int NUM_SRC = 2;
  localparam int SEL_W   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus();

  fwd_scoreboard #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  // mq[0] is the instruction that left EX most recently; bubbles have v=0.
  typedef struct {
    bit v;
    int rd;
    bit ld;
    int rdy;
  } m_ent_t;

  m_ent_t      mq[$];
  int unsigned m_cnt;
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int youngest(input int rs);
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].v && mq[k].ld && mq[k].rd != 0 && mq[k].rd == rs) return k;
    return -1;
  endfunction

  function automatic int exp_sel(input int rs);
    int k;
    k = youngest(rs);
    if (k < 0) return 0;
    if (k < mq[k].rdy) return 0;
    return k + 1;
  endfunction

  function automatic bit exp_stall();
    int k;
    if (!bus.ex_valid) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k = youngest(int'(bus.ex_rs[i]));
      if (k >= 0 && k < mq[k].rdy) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_ent_t b;
    b = '{v: 1'b0, rd: 0, ld: 1'b0, rdy: 0};
    mq.delete();
    for (int k = 0; k < DEPTH; k++) mq.push_back(b);
    m_cnt = 0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at negedge: compare every output against the model.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    for (int i = 0; i < NUM_SRC; i++) exp_q.push_back(32'(exp_sel(int'(bus.ex_rs[i]))));
    exp_q.push_back(32'(exp_stall()));
    exp_q.push_back(m_cnt);
    for (int i = 0; i < NUM_SRC; i++) begin
      e = exp_q.pop_front();
      check($sformatf("fwd_sel%0d", i), 32'(bus.fwd_sel[i]), e);
    end
    e = exp_q.pop_front();
    check("stall", 32'(bus.stall), e);
    e = exp_q.pop_front();
    check("stall_count", bus.stall_count, e);
  endtask

  // Advance the model with the current inputs, then cross the clock edge.
  task automatic tick();
    m_ent_t n;
    bit     st;
    if (rst) begin
      model_clear();
    end else if (bus.advance) begin
      st = exp_stall();
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      n = '{v: 1'b0, rd: 0, ld: 1'b0, rdy: 0};
      if (bus.ex_valid && !st && !bus.flush)
        n = '{v: 1'b1, rd: int'(bus.ex_rd), ld: bus.ex_load_reg, rdy: int'(bus.ex_ready_stage)};
      mq.push_front(n);
      void'(mq.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int rd, input bit ld, input int rdy,
                       input int rs0, input int rs1);
    bus.ex_valid       = v;
    bus.ex_rd          = 5'(rd);
    bus.ex_load_reg    = ld;
    bus.ex_ready_stage = 2'(rdy);
    bus.ex_rs[0]       = 5'(rs0);
    bus.ex_rs[1]       = 5'(rs1);
    bus.advance        = 1'b1;
    bus.flush          = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    cycle();
    check("rst_sel0", 32'(bus.fwd_sel[0]), 0);
    check("rst_stall", 32'(bus.stall), 0);

    // ALU back-to-back
    drive(1, 5, 1, 0, 0, 0); cycle(); tick();
    drive(1, 10, 1, 0, 5, 0); cycle();
    check("alu_sel0", 32'(bus.fwd_sel[0]), 1);
    check("alu_stall", 32'(bus.stall), 0);
    tick();

    // Load-use
    reset_dut();
    drive(1, 6, 1, 1, 0, 0); cycle(); tick();
    drive(1, 11, 1, 0, 0, 6); cycle();
    check("lu_stall", 32'(bus.stall), 1);
    check("lu_sel1_wait", 32'(bus.fwd_sel[1]), 0);
    tick();
    cycle();
    check("lu_sel1", 32'(bus.fwd_sel[1]), 2);
    check("lu_stall_clear", 32'(bus.stall), 0);
    check("lu_count", bus.stall_count, 1);
    tick();

    // Priority: youngest of two x7 writers
    reset_dut();
    drive(1, 7, 1, 0, 0, 0); cycle(); tick();
    drive(1, 7, 1, 0, 0, 0); cycle(); tick();
    drive(1, 20, 1, 0, 7, 7); cycle();
    check("prio_sel0", 32'(bus.fwd_sel[0]), 1);
    check("prio_sel1", 32'(bus.fwd_sel[1]), 1);
    tick();

    // x0 never forwards
    reset_dut();
    drive(1, 0, 1, 0, 0, 0); cycle(); tick();
    drive(1, 14, 1, 0, 0, 0); cycle();
    check("x0_sel0", 32'(bus.fwd_sel[0]), 0);
    check("x0_stall", 32'(bus.stall), 0);
    tick();

    // Freeze during a load-use stall
    reset_dut();
    drive(1, 9, 1, 1, 0, 0); cycle(); tick();
    drive(1, 13, 1, 0, 9, 0);
    bus.advance = 1'b0;
    repeat (3) begin
      cycle();
      check("frz_stall", 32'(bus.stall), 1);
      check("frz_count", bus.stall_count, 0);
      tick();
    end
    bus.advance = 1'b1;
    cycle(); tick();
    cycle();
    check("frz_sel0", 32'(bus.fwd_sel[0]), 2);
    check("frz_count_after", bus.stall_count, 1);
    tick();

    // Flush leaves a bubble
    reset_dut();
    drive(1, 12, 1, 0, 0, 0);
    bus.flush = 1'b1;
    cycle(); tick();
    drive(1, 15, 1, 0, 12, 12); cycle();
    check("flush_sel0", 32'(bus.fwd_sel[0]), 0);
    check("flush_sel1", 32'(bus.fwd_sel[1]), 0);
    tick();

    // Reset mid-stall
    reset_dut();
    drive(1, 6, 1, 1, 0, 0); cycle(); tick();
    drive(1, 11, 1, 0, 6, 0); cycle();
    check("rs_stall_before", 32'(bus.stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cycle();
    check("rs_stall_after", 32'(bus.stall), 0);
    check("rs_sel0", 32'(bus.fwd_sel[0]), 0);
    check("rs_count", bus.stall_count, 0);
    tick();

    // Randomized traffic over a small register window to provoke hazards
    repeat (600) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 7));
      bus.advance = ($urandom_range(0, 4) != 0);
      bus.flush   = ($urandom_range(0, 9) == 0);
      cycle();
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: number of post-EX stages tracked (entry 0 = MEM, entry 1 = WB, entry 2 = post-WB bypass latch).
REQ-002 Parameter NUM_SRC, default 2: number of EX source operands resolved per cycle.
REQ-003 Parameter SEL_W, default $clog2(DEPTH+1): width of each forwarding select.
REQ-004 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous and active-high.
REQ-006 Port advance  in  1: pipeline advance enable; 0 = global freeze (e.g. cache miss).
REQ-007 Port flush  in  1: kill the instruction currently leaving EX.
REQ-008 Port ex_valid  in  1: EX holds a real instruction.
REQ-009 Port ex_rd  in  5: EX destination register.
REQ-010 Port ex_load_reg  in  1: EX instruction writes the register file.
REQ-011 Port ex_ready_stage  in  $clog2(DEPTH): first entry index at which the EX result can be forwarded (0 = ALU, 1 = load).
REQ-012 Port ex_rs  in  NUM_SRC x 5: EX source registers.
REQ-013 Port fwd_sel  out  NUM_SRC x SEL_W: 0 = no forward (regfile/ALU-mux value), k+1 = forward from entry k.
REQ-014 Port stall  out  1: EX must hold (data hazard not yet resolvable).
REQ-015 Port stall_count  out  32: number of cycles with stall=1 and advance=1, saturating.

Function
REQ-016 Each entry SHALL hold valid, rd, load_reg, ready_stage.
REQ-017 Entry k SHALL match source i when valid, load_reg, rd != 0 and rd == ex_rs[i].
REQ-018 fwd_sel[i] SHALL select the lowest-index (youngest) matching entry; older matches are ignored.
REQ-019 A youngest match at entry k SHALL be ready iff k >= its ready_stage; if not ready, fwd_sel[i] = 0 and stall = 1.
REQ-020 stall SHALL be the OR over all sources of the not-ready condition and SHALL be 0 when ex_valid = 0.
REQ-021 ex_rs[i] = 0 SHALL always yield fwd_sel[i] = 0 and contribute no stall.
REQ-022 On advance = 1, entries SHALL shift (entry k -> k+1, entry DEPTH-1 discarded) in one cycle.
REQ-023 On advance = 1, entry 0 SHALL load the EX instruction only if ex_valid = 1, stall = 0, flush = 0; otherwise entry 0 loads a bubble (valid = 0).
REQ-024 On advance = 0, all entries and stall_count SHALL hold; fwd_sel and stall remain combinational on held state.
REQ-025 flush and stall together SHALL produce a single bubble; flush has no effect on entries 1..DEPTH-1.
REQ-026 fwd_sel and stall SHALL be combinational from current entries and ex_* inputs (zero latency); entry state has one-cycle update latency.
REQ-027 stall_count SHALL increment by 1 per qualifying cycle and saturate at 0xFFFF_FFFF.

Reset
REQ-028 rst = 1 SHALL clear every entry valid bit and stall_count to 0 on the next clock edge, overriding advance and flush.
REQ-029 Immediately after reset, fwd_sel = 0 for all sources and stall = 0.
REQ-030 Reset mid-stall SHALL abandon the stall; no entry survives.

Structure
REQ-031 A shared package SHALL define the entry struct type and the fwd_sel encoding constants (FWD_NONE = 0, FWD_ENTRY_BASE = 1).
REQ-032 Per-operand priority match and readiness check SHALL be one sub-module, fwd_operand_select, instantiated NUM_SRC times.
REQ-033 The MEM/WB forwarding mux decode in the datapath SHALL consume fwd_sel directly.

Verification
REQ-034 ALU back-to-back: issue x5 (ready 0), next EX reads rs1=x5 -> fwd_sel[0]=1, stall=0.
REQ-035 Load-use: issue load x6 (ready 1), next EX reads rs2=x6 -> stall=1 one cycle, bubble in entry 0, then fwd_sel[1]=2, stall=0; stall_count=1.
REQ-036 Priority: entries 0 and 1 both write x7, EX reads x7 on both sources -> fwd_sel={1,1}.
REQ-037 x0 and freeze: writer to x0 plus rs1=x0 -> fwd_sel[0]=0; advance=0 for 3 cycles -> entries and stall_count unchanged.
REQ-038 Flush and reset: flush with ex_valid=1 -> entry 0 invalid next cycle; rst during load-use stall -> all valid bits 0, stall=0, stall_count=0.
